// File: rtl/fx_scheduler.sv
// fx_scheduler: burst-locked round-robin arbiter sharing one moving-average effect
// among N_SRC sample sources. Define FX_SCHED_TIMEOUT_EN to enable the WAIT watchdog.
module fx_scheduler #(
  parameter int N_SRC     = 4,
  parameter int W         = 24,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SRC-1:0]         src_req,
  input  logic [N_SRC*W-1:0]       src_data,
  input  logic [N_SRC-1:0]         src_fx_on,
  output logic [N_SRC-1:0]         src_ack,
  output logic [W-1:0]             fx_data,
  output logic                     fx_wren,
  output logic                     fx_on,
  output logic                     fx_clear,
  input  logic [W-1:0]             fx_out_data,
  input  logic                     fx_out_valid,
  output logic [W-1:0]             res_data,
  output logic                     res_valid,
  output logic [$clog2(N_SRC)-1:0] res_src,
  output logic                     err
);

  localparam int IW = $clog2(N_SRC);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  if (N_SRC < 2 || N_SRC > 8 || MAX_BURST < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("fx_scheduler: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, CLEAR, ISSUE, WAIT} state_t;

  state_t          state;
  state_t          next_state;
  logic [IW-1:0]   owner;
  logic            owner_vld;
  logic [IW-1:0]   rr_ptr;
  logic [BW-1:0]   burst_cnt;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   pick_q;
  logic [IW-1:0]   cand;
  logic            pick_found;
  logic [N_SRC-1:0] owner_oh;
  logic            others_req;
  logic            keep;
  logic            clear_q;
  logic [W-1:0]    fx_data_q;
  logic            timeout;
  logic [W-1:0]    src_word [N_SRC];

  for (genvar g = 0; g < N_SRC; g++) begin : g_src_word
    assign src_word[g] = src_data[g*W +: W];
  end

  assign owner_oh   = N_SRC'(1) << owner;
  assign others_req = |(src_req & ~owner_oh);
  assign keep       = owner_vld && src_req[owner] && ((burst_cnt < BURST_MAX) || !others_req);

  // Round-robin search starts just after the last granted source.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = IW'((int'(rr_ptr) + k) % N_SRC);
      if (!pick_found && src_req[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (keep) begin
          next_state = ISSUE;
        end else if (pick_found) begin
          next_state = (pick != owner || !owner_vld) ? CLEAR : ISSUE;
        end
      end
      CLEAR:   next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT: begin
        if (fx_out_valid || timeout) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    fx_wren = 1'b0;
    src_ack = '0;
    fx_data = fx_data_q;
    if (state == ISSUE) begin
      fx_wren = 1'b1;
      src_ack = owner_oh;
      fx_data = src_word[owner];
    end
  end

  // The effect is flushed for the whole time reset is held, not just after it.
  assign fx_clear = clear_q | reset;
  assign fx_on    = src_fx_on[owner] & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= '0;
      owner_vld <= 1'b0;
      rr_ptr    <= IW'(N_SRC - 1);
      burst_cnt <= '0;
      pick_q    <= '0;
      clear_q   <= 1'b0;
      fx_data_q <= '0;
      res_data  <= '0;
      res_src   <= '0;
      res_valid <= 1'b0;
    end else begin
      clear_q   <= (next_state == CLEAR);
      res_valid <= 1'b0;
      fx_data_q <= fx_data;
      if (state == IDLE && next_state == CLEAR) begin
        pick_q <= pick;
      end
      case (state)
        CLEAR: begin
          owner     <= pick_q;
          owner_vld <= 1'b1;
          rr_ptr    <= pick_q;
          burst_cnt <= '0;
        end
        ISSUE: begin
          if (burst_cnt != BURST_MAX) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (fx_out_valid) begin
            res_data  <= fx_out_data;
            res_src   <= owner;
            res_valid <= 1'b1;
          end else if (timeout) begin
            owner_vld <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FX_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] wait_cnt;
  logic          err_q;

  assign timeout = (state == WAIT) && !fx_out_valid && (wait_cnt == WAIT_LAST);
  assign err     = err_q;

  // Dropping owner_vld on a timeout forces the next grant through CLEAR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != WAIT) begin
        wait_cnt <= '0;
      end else if (!timeout) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_fx_scheduler.sv
// tb_fx_scheduler: directed scoreboard bench for fx_scheduler with a behavioural
// 8-tap moving-average effect model. FX_SCHED_TIMEOUT_EN adds the watchdog test.
module tb_fx_scheduler;

  localparam int N_SRC = 4;
  localparam int W     = 24;
  localparam int IW    = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [N_SRC-1:0]   src_req = '0;
  logic [N_SRC*W-1:0] src_data = '0;
  logic [N_SRC-1:0]   src_fx_on = '1;
  logic [N_SRC-1:0]   src_ack;
  logic [W-1:0]       fx_data;
  logic               fx_wren;
  logic               fx_on;
  logic               fx_clear;
  logic [W-1:0]       fx_out_data = '0;
  logic               fx_out_valid = 1'b0;
  logic [W-1:0]       res_data;
  logic               res_valid;
  logic [IW-1:0]      res_src;
  logic               err;

  fx_scheduler #(.N_SRC(N_SRC), .W(W), .MAX_BURST(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .src_req(src_req), .src_data(src_data),
    .src_fx_on(src_fx_on), .src_ack(src_ack), .fx_data(fx_data),
    .fx_wren(fx_wren), .fx_on(fx_on), .fx_clear(fx_clear),
    .fx_out_data(fx_out_data), .fx_out_valid(fx_out_valid),
    .res_data(res_data), .res_valid(res_valid), .res_src(res_src), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Effect model: 8-tap moving average with sync clear, bypass when fx_on=0.
  logic signed [W-1:0] hist [8];
  logic fx_stuck = 1'b0;
  always @(posedge clk) begin
    longint sum;
    fx_out_valid <= 1'b0;
    if (fx_clear) begin
      for (int k = 0; k < 8; k++) hist[k] <= '0;
    end else if (fx_wren) begin
      if (fx_on) begin
        sum = longint'(signed'(fx_data));
        for (int k = 0; k < 7; k++) sum += longint'(hist[k]);
        for (int k = 7; k > 0; k--) hist[k] <= hist[k-1];
        hist[0] <= signed'(fx_data);
        fx_out_data <= W'(sum >>> 3);
      end else begin
        fx_out_data <= fx_data;
      end
      fx_out_valid <= !fx_stuck;
    end
  end

  // Per-source sample FIFOs; the driver advances a source after its ack cycle.
  logic [W-1:0] src_buf [N_SRC][32];
  int src_wr [N_SRC];
  int src_rd [N_SRC];

  task automatic applyStimulus(input int src, input logic [W-1:0] data);
    src_buf[src][src_wr[src] % 32] = data;
    src_wr[src] = src_wr[src] + 1;
  endtask

  initial begin
    logic [N_SRC-1:0] acked;
    forever begin
      @(negedge clk);
      acked = src_ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_SRC; i++) begin
        if (reset) src_rd[i] = src_wr[i];
        else if (acked[i] && src_rd[i] != src_wr[i]) src_rd[i] = src_rd[i] + 1;
        src_req[i] = (src_rd[i] != src_wr[i]);
        src_data[i*W +: W] = src_req[i] ? src_buf[i][src_rd[i] % 32] : '0;
      end
    end
  end

  typedef struct packed {
    logic [W-1:0]  data;
    logic [IW-1:0] src;
  } res_t;
  res_t exp_q [$];

  task automatic expectResult(input int src, input logic [W-1:0] data);
    res_t e;
    e.data = data;
    e.src  = IW'(src);
    exp_q.push_back(e);
  endtask

  int clear_cnt = 0, wren_cnt = 0, wren_on_cnt = 0, back2back = 0;
  bit log_en = 1'b0;
  int ack_log [$];
  int res_log [$];
  int clear_log [$];

  initial begin
    res_t e;
    logic prev_wren;
    prev_wren = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (fx_clear) begin
          clear_cnt++;
          if (log_en) clear_log.push_back(cyc);
        end
        if (fx_wren) begin
          wren_cnt++;
          if (fx_on) wren_on_cnt++;
          if (prev_wren) back2back++;
        end
        if (log_en && |src_ack) ack_log.push_back(cyc);
        if (res_valid) begin
          if (log_en) res_log.push_back(cyc);
          checkOutput("res_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("res_data", res_data, e.data);
            checkOutput("res_src", res_src, e.src);
          end
        end
      end
      prev_wren = fx_wren;
    end
  end

  task automatic waitDrain(input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0);
      for (int i = 0; i < N_SRC; i++) if (src_rd[i] != src_wr[i]) done = 1'b0;
    end
    checkOutput("drain", done, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic waitWren(input string name);
    int n;
    n = 0;
    while (!fx_wren && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, fx_wren, 1);
  endtask

  initial begin
    int c0, cl0, bb0, w0, wo0, wcyc;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_wren", fx_wren, 0);
    checkOutput("rst_ack", src_ack, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_fx_data", fx_data, 0);
    checkOutput("rst_res_data", res_data, 0);
    checkOutput("rst_res_src", res_src, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_fx_on", fx_on, 0);
    checkOutput("rst_fx_clear", fx_clear, 1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_clear", fx_clear, 0);

    // T1: single source, three samples, cycle-exact timing
    @(negedge clk);
    log_en = 1'b1;
    c0 = cyc + 1;
    for (int k = 0; k < 3; k++) applyStimulus(0, 24'h000100);
    expectResult(0, 24'h000020);
    expectResult(0, 24'h000040);
    expectResult(0, 24'h000060);
    waitDrain(200);
    log_en = 1'b0;
    checkOutput("t1_clear_n", clear_log.size(), 1);
    if (clear_log.size() > 0) checkOutput("t1_clear_cyc", clear_log[0] - c0, 1);
    checkOutput("t1_ack_n", ack_log.size(), 3);
    for (int k = 0; k < ack_log.size() && k < 3; k++) checkOutput("t1_ack_cyc", ack_log[k] - c0, 2 + 3*k);
    checkOutput("t1_res_n", res_log.size(), 3);
    for (int k = 0; k < res_log.size() && k < 3; k++) checkOutput("t1_res_cyc", res_log[k] - c0, 4 + 3*k);

    // T2: two continuous requesters, burst limit of 8
    doReset();
    cl0 = clear_cnt;
    bb0 = back2back;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(0, 24'h000800);
      applyStimulus(1, 24'h001000);
    end
    for (int k = 1; k <= 8; k++) expectResult(0, 24'(k * 'h100));
    for (int k = 1; k <= 8; k++) expectResult(1, 24'(k * 'h200));
    expectResult(0, 24'h000100);
    expectResult(1, 24'h000200);
    waitDrain(500);
    checkOutput("t2_clears", clear_cnt - cl0, 4);
    checkOutput("t2_back2back_wren", back2back - bb0, 0);

    // T3: bypassed source
    cl0 = clear_cnt;
    w0  = wren_cnt;
    wo0 = wren_on_cnt;
    src_fx_on = 4'b1011;
    applyStimulus(2, 24'h123456);
    applyStimulus(2, 24'hFEDCBA);
    expectResult(2, 24'h123456);
    expectResult(2, 24'hFEDCBA);
    waitDrain(200);
    checkOutput("t3_wren_n", wren_cnt - w0, 2);
    checkOutput("t3_wren_fx_on", wren_on_cnt - wo0, 0);
    checkOutput("t3_clears", clear_cnt - cl0, 1);
    src_fx_on = '1;

    // T4: src0 ends its burst early, src3 takes over, src0 returns flushed
    doReset();
    cl0 = clear_cnt;
    applyStimulus(0, 24'h000080);
    applyStimulus(0, 24'h000080);
    applyStimulus(3, 24'h000400);
    applyStimulus(3, 24'h000400);
    expectResult(0, 24'h000010);
    expectResult(0, 24'h000020);
    expectResult(3, 24'h000080);
    expectResult(3, 24'h000100);
    waitDrain(200);
    applyStimulus(0, 24'h000080);
    expectResult(0, 24'h000010);
    waitDrain(200);
    checkOutput("t4_clears", clear_cnt - cl0, 3);

    // T5: reset during WAIT drops the result; src0 wins the first grant after
    fx_stuck = 1'b1;
    applyStimulus(1, 24'h000999);
    waitWren("t5_issue");
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("t5_wren", fx_wren, 0);
    checkOutput("t5_ack", src_ack, 0);
    checkOutput("t5_res_valid", res_valid, 0);
    checkOutput("t5_fx_data", fx_data, 0);
    checkOutput("t5_res_data", res_data, 0);
    checkOutput("t5_fx_on", fx_on, 0);
    checkOutput("t5_fx_clear", fx_clear, 1);
    repeat (2) @(negedge clk);
    checkOutput("t5_clear_held", fx_clear, 1);
    fx_stuck = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(1, 24'h000800);
    applyStimulus(0, 24'h000400);
    expectResult(0, 24'h000080);
    expectResult(1, 24'h000100);
    waitDrain(200);

`ifdef FX_SCHED_TIMEOUT_EN
    // T6: watchdog
    fx_stuck = 1'b1;
    applyStimulus(2, 24'h000800);
    waitWren("t6_issue");
    wcyc = cyc;
    repeat (15) @(negedge clk);
    checkOutput("t6_wait_cycles", cyc - wcyc, 15);
    checkOutput("t6_err_before", err, 0);
    @(negedge clk);
    checkOutput("t6_err_after", err, 1);
    fx_stuck = 1'b0;
    repeat (3) @(negedge clk);
    cl0 = clear_cnt;
    applyStimulus(2, 24'h000800);
    expectResult(2, 24'h000100);
    waitDrain(200);
    checkOutput("t6_clears", clear_cnt - cl0, 1);
    checkOutput("t6_err_sticky", err, 1);
    doReset();
    checkOutput("t6_err_cleared", err, 0);
`else
    checkOutput("err_tied_low", err, 0);
`endif

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/fx_scheduler.md
# fx_scheduler

Sequencer and arbiter that shares one moving-average effect unit (24-bit signed, `wren`/`on`/sync `reset` input side, `out_data`/`out_valid` output side) among several audio sample sources. It grants the effect to one source at a time with burst locking and round-robin fairness. It flushes the filter's delay-line history whenever ownership changes, so no two sources' histories mix. It issues exactly one single-cycle write per sample and returns each filtered result tagged with its source index.

## Interface
- N_SRC, 4: number of requesting sources (2..8)
- W, 24: sample width
- MAX_BURST, 8: consecutive samples an owner may issue while others wait
- TIMEOUT, 15: WAIT-state watchdog limit in cycles (used only with FX_SCHED_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- src_req  in  N_SRC  per-source sample-request
- src_data  in  N_SRC*W  per-source sample, source i at [i*W +: W]
- src_fx_on  in  N_SRC  per-source effect enable (0 = bypass)
- src_ack  out  N_SRC  one-hot, one-cycle sample-consumed strobe
- fx_data  out  W  sample to the effect
- fx_wren  out  1  effect write strobe, single cycle
- fx_on  out  1  effect enable for the issued sample
- fx_clear  out  1  drives the effect's sync reset
- fx_out_data  in  W  effect result
- fx_out_valid  in  1  effect result valid
- res_data  out  W  captured result
- res_valid  out  1  one-cycle result strobe
- res_src  out  clog2(N_SRC)  source index of res_data
- err  out  1  sticky watchdog error

## Operation
- States: IDLE, CLEAR, ISSUE, WAIT.
- Registers: owner, owner_vld, rr_ptr, burst_cnt.
- IDLE arbitration:
  - Keep the current owner if `src_req[owner]` is high, owner_vld=1, and either burst_cnt<MAX_BURST or no other req is pending. Then go to ISSUE.
  - Otherwise pick the first requesting index after rr_ptr, in cyclic order. Go to CLEAR if the pick differs from owner or owner_vld=0; otherwise go to ISSUE.
  - No req: stay in IDLE.
- CLEAR: fx_clear=1 for one cycle; owner←pick, owner_vld←1, rr_ptr←pick, burst_cnt←0; go to ISSUE.
- ISSUE:
  - fx_wren=1, fx_data=src_data[owner], fx_on=src_fx_on[owner], src_ack[owner]=1.
  - burst_cnt increments, saturating at MAX_BURST.
  - Go to WAIT.
- WAIT: on fx_out_valid, register res_data←fx_out_data, res_src←owner, res_valid←1, then go to IDLE.
- Outside ISSUE:
  - fx_wren=0, src_ack=0.
  - fx_data holds its last value.
  - fx_on=src_fx_on[owner].
- Requester rule: hold src_data stable while req is high. The sample is consumed in the ack cycle. The next sample is presented in the following cycle if req stays high.
- Dropping req in the ack cycle or later ends the burst; owner_vld remains set (history intact).
- Arithmetic: data passes through unmodified. Widths are fixed at W; no sign handling is performed in this block.

## Timing
- Reset (async): state=IDLE, all outputs 0, owner=0, owner_vld=0, rr_ptr=N_SRC-1 (source 0 wins first), burst_cnt=0, err=0.
- fx_clear = registered clear | reset, so the filter is flushed while reset is held.
- Same-owner sample: IDLE(c0) → ISSUE(c1: ack, wren) → WAIT(c2: fx_out_valid) → res_valid in c3, which is also IDLE. Throughput is 1 sample per 3 cycles.
- Owner switch adds one CLEAR cycle: 4 cycles per sample.
- Filter history refills after 8 issued samples. The first 7 results after a switch are partial averages by design.
- Simultaneous requests: rr order decides; the lower index is not favoured beyond rr_ptr.
- fx_out_valid outside WAIT is ignored.
- Reset mid-WAIT: the result is dropped, no res_valid is produced, and the owner is invalidated.

## Configuration
- FX_SCHED_TIMEOUT_EN defined:
  - A WAIT cycle counter runs.
  - If TIMEOUT cycles elapse without fx_out_valid, err←1 (sticky until reset), no res_valid is produced, owner_vld←0 (forces CLEAR), and the state goes to IDLE.
- Undefined: WAIT waits indefinitely; err is tied 0; no counter logic.

## Test plan
- Src0 req with 0x000100 for 3 samples, fx_on=1, model effect (1-cycle valid):
  - fx_clear pulses once at c1.
  - Acks at c2, c5, c8.
  - res_valid at c4, c7, c10 with res_src=0.
- Src0 and src1 continuously requesting, MAX_BURST=8: results show 8×src0, one CLEAR cycle, 8×src1, CLEAR, repeating; never two wren in consecutive cycles.
- src_fx_on[2]=0 while src2 is owner: fx_on=0 during every ISSUE; res_data equals the modelled bypass output.
- Src0 drops req mid-burst while src3 is requesting: the next grant is src3 via CLEAR. Src0 re-requesting later passes through CLEAR again.
- With FX_SCHED_TIMEOUT_EN and fx_out_valid stuck 0:
  - err rises after 15 WAIT cycles and no res_valid is produced.
  - The next request goes through CLEAR.
  - err stays 1 until reset.
- Assert reset during WAIT:
  - All outputs go 0 immediately; fx_clear=1 while reset is held.
  - After release, simultaneous req on src1 and src0 grants src0 first.
